// File: rtl/cachePkg.sv
// Shared command, state and transaction types for the next-level line arbiter.
package cachePkg;

    localparam int unsigned STAT_W = 32;

    typedef enum logic [1:0] {
        NOP       = 2'd0,
        READ_OUT  = 2'd1,
        WRITE_OUT = 2'd2
    } lnext_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } lnext_state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } lnext_owner_t;

    // Latched transaction context, held for the whole transfer.
    typedef struct packed {
        lnext_owner_t owner;
        lnext_cmd_t   cmd;
    } lnext_txn_t;

    // Saturating increment used by the optional statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last is chosen.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic prefer_hi_q;

    always_comb begin
        grant = req;
        if (&req) begin
            grant = prefer_hi_q ? 2'b10 : 2'b01;
        end
    end

    // After a grant the other requester gets priority on the next tie.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prefer_hi_q <= 1'b0;
        end else if (advance && (|grant)) begin
            prefer_hi_q <= grant[0];
        end
    end

endmodule

// File: rtl/lnext_arbiter.sv
// Arbitrates I-cache and D-cache line transfers onto a single next-level port.
// Optional statistics counters are built when LNEXT_STATS_EN is defined.
module lnext_arbiter
    import cachePkg::*;
#(
    parameter int unsigned ADDRBITS     = 32,
    parameter int unsigned LINEADDRBITS = ADDRBITS - 6,
    parameter int unsigned WORDW        = 32,
    parameter int unsigned BEATS        = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    ic_req,
    input  logic [LINEADDRBITS-1:0] ic_addr,
    input  logic                    dc_req,
    input  lnext_cmd_t              dc_cmd,
    input  logic [LINEADDRBITS-1:0] dc_addr,
    input  logic [WORDW-1:0]        dc_wdata,
    output logic                    ic_gnt,
    output logic                    dc_gnt,
    output logic                    ic_done,
    output logic                    dc_done,
    output logic [WORDW-1:0]        rdata,
    output logic                    ic_rvalid,
    output logic                    dc_rvalid,
    output logic                    dc_wready,
    output logic                    ln_valid,
    output lnext_cmd_t              ln_cmd,
    output logic [LINEADDRBITS-1:0] ln_addr,
    input  logic                    ln_ready,
    input  logic [WORDW-1:0]        ln_rdata,
    input  logic                    ln_rvalid,
    output logic [WORDW-1:0]        ln_wdata,
`ifdef LNEXT_STATS_EN
    output logic [STAT_W-1:0]       ic_grants,
    output logic [STAT_W-1:0]       dc_grants,
    output logic [STAT_W-1:0]       conflicts,
`endif
    input  logic                    ln_wready
);

    localparam int unsigned CNTW = $clog2(BEATS) + 1;

    lnext_state_t            state_q;
    lnext_state_t            state_d;
    lnext_txn_t              txn_q;
    logic [LINEADDRBITS-1:0] addr_q;
    logic [CNTW-1:0]         beat_q;
    logic [CNTW-1:0]         beat_d;
    logic                    gnt_q;
    logic                    take;
    logic                    beat_hit;
    logic                    dc_valid;
    logic                    is_read;
    logic [1:0]              req_vec;
    logic [1:0]              grant;

    // A D-cache request carrying NOP is not a request at all.
    assign dc_valid = dc_req && ((dc_cmd == READ_OUT) || (dc_cmd == WRITE_OUT));
    assign req_vec  = {dc_valid, ic_req};
    assign is_read  = (txn_q.cmd == READ_OUT);

    rr_arb2 u_rr (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req_vec),
        .advance (take),
        .grant   (grant)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            txn_q.owner <= OWN_IC;
            txn_q.cmd   <= NOP;
            addr_q      <= '0;
            beat_q      <= '0;
            gnt_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            gnt_q   <= take;
            if (take) begin
                txn_q.owner <= grant[1] ? OWN_DC : OWN_IC;
                txn_q.cmd   <= grant[1] ? dc_cmd : READ_OUT;
                addr_q      <= grant[1] ? dc_addr : ic_addr;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        take      = 1'b0;
        beat_hit  = 1'b0;
        ln_valid  = 1'b0;
        ln_cmd    = NOP;
        ln_addr   = '0;
        rdata     = '0;
        ln_wdata  = '0;
        ic_rvalid = 1'b0;
        dc_rvalid = 1'b0;
        dc_wready = 1'b0;
        ic_done   = 1'b0;
        dc_done   = 1'b0;
        // gnt_q is only set for the first ISSUE cycle.
        ic_gnt    = gnt_q && (txn_q.owner == OWN_IC);
        dc_gnt    = gnt_q && (txn_q.owner == OWN_DC);

        unique case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    take    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                ln_valid = 1'b1;
                ln_cmd   = txn_q.cmd;
                ln_addr  = addr_q;
                if (ln_ready) begin
                    state_d = XFER;
                    beat_d  = '0;
                end
            end
            XFER: begin
                if (is_read) begin
                    if (ln_rvalid) begin
                        rdata = ln_rdata;
                    end
                    ic_rvalid = ln_rvalid && (txn_q.owner == OWN_IC);
                    dc_rvalid = ln_rvalid && (txn_q.owner == OWN_DC);
                    beat_hit  = ln_rvalid;
                end else begin
                    // Writes always belong to the D-cache.
                    ln_wdata  = dc_wdata;
                    dc_wready = ln_wready;
                    beat_hit  = ln_wready;
                end
                if (beat_hit) begin
                    beat_d = beat_q + CNTW'(1);
                    if (beat_q == CNTW'(BEATS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                ic_done = (txn_q.owner == OWN_IC);
                dc_done = (txn_q.owner == OWN_DC);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef LNEXT_STATS_EN
    logic conflict_c;

    assign conflict_c = (state_q == IDLE) && (&req_vec);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ic_grants <= '0;
            dc_grants <= '0;
            conflicts <= '0;
        end else begin
            if (take && grant[0]) begin
                ic_grants <= sat_inc(ic_grants);
            end
            if (take && grant[1]) begin
                dc_grants <= sat_inc(dc_grants);
            end
            if (conflict_c) begin
                conflicts <= sat_inc(conflicts);
            end
        end
    end
`endif

endmodule

// File: tb/tb_lnext_arbiter.sv
// Bench for lnext_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_lnext_arbiter;
    import cachePkg::*;

    localparam int unsigned LA    = 26;
    localparam int unsigned W     = 32;
    localparam int unsigned BEATS = 16;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b1;
    logic          ic_req;
    logic [LA-1:0] ic_addr;
    logic          dc_req;
    lnext_cmd_t    dc_cmd;
    logic [LA-1:0] dc_addr;
    logic [W-1:0]  dc_wdata;
    logic          ic_gnt, dc_gnt, ic_done, dc_done;
    logic [W-1:0]  rdata;
    logic          ic_rvalid, dc_rvalid, dc_wready;
    logic          ln_valid;
    lnext_cmd_t    ln_cmd;
    logic [LA-1:0] ln_addr;
    logic          ln_ready;
    logic [W-1:0]  ln_rdata;
    logic          ln_rvalid;
    logic [W-1:0]  ln_wdata;
    logic          ln_wready;
`ifdef LNEXT_STATS_EN
    logic [31:0]   ic_grants, dc_grants, conflicts;
`endif

    int checks   = 0;
    int failures = 0;

    lnext_arbiter #(
        .ADDRBITS     (32),
        .LINEADDRBITS (LA),
        .WORDW        (W),
        .BEATS        (BEATS)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .dc_req    (dc_req),
        .dc_cmd    (dc_cmd),
        .dc_addr   (dc_addr),
        .dc_wdata  (dc_wdata),
        .ic_gnt    (ic_gnt),
        .dc_gnt    (dc_gnt),
        .ic_done   (ic_done),
        .dc_done   (dc_done),
        .rdata     (rdata),
        .ic_rvalid (ic_rvalid),
        .dc_rvalid (dc_rvalid),
        .dc_wready (dc_wready),
        .ln_valid  (ln_valid),
        .ln_cmd    (ln_cmd),
        .ln_addr   (ln_addr),
        .ln_ready  (ln_ready),
        .ln_rdata  (ln_rdata),
        .ln_rvalid (ln_rvalid),
        .ln_wdata  (ln_wdata),
`ifdef LNEXT_STATS_EN
        .ic_grants (ic_grants),
        .dc_grants (dc_grants),
        .conflicts (conflicts),
`endif
        .ln_wready (ln_wready)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Flag order: ic_gnt dc_gnt ic_done dc_done ic_rvalid dc_rvalid dc_wready ln_valid
    function automatic logic [127:0] pack(input logic [7:0] flags, input logic [1:0] cmd,
                                          input logic [LA-1:0] addr, input logic [W-1:0] rd,
                                          input logic [W-1:0] wd);
        return {28'd0, flags, cmd, addr, rd, wd};
    endfunction

    function automatic logic [7:0] flags_now();
        return {ic_gnt, dc_gnt, ic_done, dc_done, ic_rvalid, dc_rvalid, dc_wready, ln_valid};
    endfunction

    function automatic logic [127:0] obs_all();
        return pack(flags_now(), ln_cmd, ln_addr, rdata, ln_wdata);
    endfunction

    function automatic logic [127:0] obs_masked(input logic mv, input logic mr, input logic mw);
        return pack(flags_now(), mv ? 2'(ln_cmd) : 2'd0, mv ? ln_addr : '0,
                    mr ? rdata : '0, mw ? ln_wdata : '0);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_cmd = NOP; dc_addr = '0;
        dc_wdata = '0; ln_ready = 1'b0; ln_rdata = '0; ln_rvalid = 1'b0; ln_wready = 1'b0;
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic apply_reset(input string name);
        idle_inputs();
        reset_n = 1'b0;
        #1;
        check(name, obs_all(), '0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic       ic_req;
        logic       dc_req;
        lnext_cmd_t dc_cmd;
        logic       ln_ready;
        logic [7:0] flags;
        lnext_cmd_t cmd;
    } vec_t;

    task automatic run_table();
        vec_t tbl[8];
        logic [LA-1:0] va = 26'h155AA55;
        tbl[0] = '{1'b0, 1'b0, NOP,      1'b0, 8'h00, NOP};
        tbl[1] = '{1'b0, 1'b1, NOP,      1'b0, 8'h00, NOP};
        tbl[2] = '{1'b0, 1'b1, NOP,      1'b1, 8'h00, NOP};
        tbl[3] = '{1'b1, 1'b1, READ_OUT, 1'b0, 8'h00, NOP};
        tbl[4] = '{1'b1, 1'b1, READ_OUT, 1'b0, 8'h81, READ_OUT};
        tbl[5] = '{1'b1, 1'b1, READ_OUT, 1'b0, 8'h01, READ_OUT};
        tbl[6] = '{1'b1, 1'b1, READ_OUT, 1'b1, 8'h01, READ_OUT};
        tbl[7] = '{1'b0, 1'b0, NOP,      1'b0, 8'h00, NOP};
        ic_addr = va;
        dc_addr = 26'h3000001;
        for (int i = 0; i < 8; i++) begin
            next();
            ic_req   = tbl[i].ic_req;
            dc_req   = tbl[i].dc_req;
            dc_cmd   = tbl[i].dc_cmd;
            ln_ready = tbl[i].ln_ready;
            settle();
            check($sformatf("vec%0d", i), obs_masked(tbl[i].flags[0], 1'b0, 1'b0),
                  pack(tbl[i].flags, tbl[i].cmd, tbl[i].flags[0] ? va : '0, '0, '0));
        end
`ifdef LNEXT_STATS_EN
        check("stat_conflicts", 128'(conflicts), 128'(1));
        check("stat_ic_grants", 128'(ic_grants), 128'(1));
        check("stat_dc_grants", 128'(dc_grants), 128'(0));
`endif
    endtask

    // Single I-cache fill with a ready next level.
    task automatic seq_ic_fill();
        logic [W-1:0] d;
        next();
        ic_req = 1'b1; ic_addr = 26'h0000123; ln_ready = 1'b1;
        settle();
        check("a_idle", obs_all(), '0);
        next();
        ic_req = 1'b0;
        settle();
        check("a_gnt", obs_masked(1'b1, 1'b0, 1'b0), pack(8'h81, READ_OUT, 26'h0000123, '0, '0));
        for (int b = 0; b < int'(BEATS); b++) begin
            next();
            d = 32'hA500_0000 | W'(b);
            ln_rvalid = 1'b1; ln_rdata = d;
            settle();
            check($sformatf("a_beat%0d", b), obs_masked(1'b0, 1'b1, 1'b0), pack(8'h08, 2'd0, '0, d, '0));
        end
        next();
        ln_rvalid = 1'b0;
        settle();
        check("a_done", obs_masked(1'b0, 1'b0, 1'b0), pack(8'h20, 2'd0, '0, '0, '0));
        next();
        settle();
        check("a_done_once", obs_masked(1'b0, 1'b0, 1'b0), '0);
    endtask

    // Both caches request continuously; grants must alternate starting with ic.
    task automatic seq_round_robin();
        int order[$];
        int b_exp[3] = '{0, 1, 0};
        next();
        ic_req = 1'b1; ic_addr = 26'h0000ABC;
        dc_req = 1'b1; dc_cmd = READ_OUT; dc_addr = 26'h0000DEF;
        ln_ready = 1'b1; ln_rvalid = 1'b1;
        for (int c = 0; c < 200 && order.size() < 3; c++) begin
            settle();
            if (ic_gnt || dc_gnt) begin
                check($sformatf("b_single_gnt%0d", order.size()), 128'(ic_gnt & dc_gnt), '0);
            end
            if (ic_gnt) order.push_back(0);
            if (dc_gnt) order.push_back(1);
            next();
        end
        check("b_grants_seen", 128'(order.size()), 128'(3));
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b_order%0d", i), 128'(i < order.size() ? order[i] : 9), 128'(b_exp[i]));
        end
    endtask

    // D-cache write with a stalled command phase and gaps in ln_wready.
    task automatic seq_dc_write();
        int nb = 0;
        int dones = 0;
        next();
        dc_req = 1'b1; dc_cmd = WRITE_OUT; dc_addr = 26'h2ABCDEF; ln_ready = 1'b0;
        settle();
        check("c_idle", obs_all(), '0);
        for (int c = 0; c < 6; c++) begin
            next();
            dc_req = 1'b0; dc_cmd = NOP; ln_ready = (c == 5);
            settle();
            check($sformatf("c_hold%0d", c), obs_masked(1'b1, 1'b0, 1'b0),
                  pack((c == 0) ? 8'h41 : 8'h01, WRITE_OUT, 26'h2ABCDEF, '0, '0));
        end
        for (int c = 0; c < 40 && nb < int'(BEATS); c++) begin
            next();
            ln_ready = 1'b0; ln_wready = ((c % 4) != 3); dc_wdata = $urandom;
            settle();
            check($sformatf("c_w%0d", c), obs_masked(1'b0, 1'b0, 1'b1),
                  pack(ln_wready ? 8'h02 : 8'h00, 2'd0, '0, '0, dc_wdata));
            if (ln_wready) nb++;
        end
        check("c_beats", 128'(nb), 128'(BEATS));
        next();
        ln_wready = 1'b0;
        settle();
        check("c_done", obs_masked(1'b0, 1'b0, 1'b0), pack(8'h10, 2'd0, '0, '0, '0));
        for (int c = 0; c < 3; c++) begin
            next();
            settle();
            dones += int'(dc_done);
        end
        check("c_done_once", 128'(dones), '0);
    endtask

    // Reset in the middle of a read transfer, then a clean transaction.
    task automatic seq_reset_mid();
        int  quiet = 0;
        int  nrv = 0;
        bit  got = 1'b0;
        bit  seen_gnt = 1'b0;
        next();
        ic_req = 1'b1; ic_addr = 26'h0ABCDE0; ln_ready = 1'b1;
        next();
        ic_req = 1'b0;
        for (int b = 0; b < 7; b++) begin
            next();
            ln_rvalid = 1'b1; ln_rdata = $urandom;
        end
        settle();
        check("d_beat7", 128'(ic_rvalid), 128'(1));
        reset_n = 1'b0;
        #1;
        check("d_reset_out", obs_all(), '0);
        next();
        reset_n = 1'b1;
        ln_wready = 1'b1;
        for (int c = 0; c < 25; c++) begin
            settle();
            quiet += int'(ic_done) + int'(dc_done) + int'(ic_rvalid) + int'(dc_rvalid);
            next();
        end
        check("d_abandoned", 128'(quiet), '0);
        ic_req = 1'b1; ic_addr = 26'h0000456;
        for (int c = 0; c < 60 && !got; c++) begin
            settle();
            seen_gnt |= ic_gnt;
            nrv += int'(ic_rvalid);
            got = ic_done;
            next();
            if (seen_gnt) ic_req = 1'b0;
        end
        check("d_recover_done", 128'(got), 128'(1));
        check("d_recover_beats", 128'(nrv), 128'(BEATS));
    endtask

    // Random traffic against a transaction-level model of the arbiter.
    task automatic random_phase(input int ncyc);
        bit busy = 0, sent = 0, first = 0, own_dc = 0, prefer_dc = 0;
        int beats = 0;
        lnext_cmd_t mcmd = NOP;
        logic [LA-1:0] maddr = '0;
        bit ic_pend = 0, dc_pend = 0;
        bit icv, dcv, xfer, rd, ir, dr, wr;
        logic [7:0] ef;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            next();
            if (!ic_pend && $urandom_range(0, 3) == 0) begin
                ic_pend = 1'b1; ic_addr = LA'($urandom);
            end
            if (!dc_pend && $urandom_range(0, 3) == 0) begin
                dc_pend = 1'b1; dc_addr = LA'($urandom);
                dc_cmd = ($urandom_range(0, 1) == 1) ? WRITE_OUT : READ_OUT;
            end
            ic_req = ic_pend;
            if (dc_pend) begin
                dc_req = 1'b1;
            end else begin
                dc_req = ($urandom_range(0, 7) == 0);
                dc_cmd = NOP;
            end
            ln_ready  = ($urandom_range(0, 2) != 0);
            ln_rvalid = ($urandom_range(0, 3) != 0);
            ln_wready = ($urandom_range(0, 3) != 0);
            ln_rdata  = $urandom;
            dc_wdata  = $urandom;
            settle();
            rd   = (mcmd == READ_OUT);
            xfer = busy && sent && (beats < int'(BEATS));
            ir   = xfer && rd && ln_rvalid && !own_dc;
            dr   = xfer && rd && ln_rvalid && own_dc;
            wr   = xfer && !rd && ln_wready;
            ef   = {busy && first && !own_dc, busy && first && own_dc,
                    busy && sent && (beats == int'(BEATS)) && !own_dc,
                    busy && sent && (beats == int'(BEATS)) && own_dc,
                    ir, dr, wr, busy && !sent};
            check($sformatf("rand%0d", cyc), obs_masked(ef[0], ir || dr, xfer && !rd),
                  pack(ef, ef[0] ? 2'(mcmd) : 2'd0, ef[0] ? maddr : '0,
                       (ir || dr) ? ln_rdata : '0, (xfer && !rd) ? dc_wdata : '0));
            icv = ic_req;
            dcv = dc_req && ((dc_cmd == READ_OUT) || (dc_cmd == WRITE_OUT));
            if (!busy) begin
                if (icv || dcv) begin
                    own_dc    = dcv && (!icv || prefer_dc);
                    prefer_dc = !own_dc;
                    mcmd      = own_dc ? dc_cmd : READ_OUT;
                    maddr     = own_dc ? dc_addr : ic_addr;
                    busy = 1'b1; sent = 1'b0; first = 1'b1; beats = 0;
                    if (own_dc) dc_pend = 1'b0;
                    else        ic_pend = 1'b0;
                end
            end else if (!sent) begin
                first = 1'b0;
                sent  = ln_ready;
            end else if (beats < int'(BEATS)) begin
                if (rd ? ln_rvalid : ln_wready) beats++;
            end else begin
                busy = 1'b0;
            end
        end
    endtask

    initial begin
        idle_inputs();
        #2;
        apply_reset("reset_state");
        run_table();
        apply_reset("reset_after_table");
        seq_ic_fill();
        apply_reset("reset_after_fill");
        seq_round_robin();
        apply_reset("reset_after_rr");
        seq_dc_write();
        apply_reset("reset_after_write");
        seq_reset_mid();
        apply_reset("reset_before_random");
        random_phase(2500);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lnext_arbiter.md
LNEXT_ARBITER -- requirements
Module: lnext_arbiter

Interface
REQ-001 SHALL have parameters: ADDRBITS, default 32, byte address width; LINEADDRBITS, default ADDRBITS-6, line address width; WORDW, default 32, data beat width; BEATS, default 16, beats per line transfer.
REQ-002 SHALL have ports: clock  in  1  sole clock, all state changes on rising edge.
REQ-003 SHALL have ports: reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: ic_req  in  1  instruction-cache line-fill request, held until ic_gnt.
REQ-005 SHALL have ports: ic_addr  in  LINEADDRBITS  instruction-cache line address.
REQ-006 SHALL have ports: dc_req  in  1  and dc_cmd  in  lnext_cmd_t, data-cache request and command (READ_OUT or WRITE_OUT).
REQ-007 SHALL have ports: dc_addr  in  LINEADDRBITS, and dc_wdata  in  WORDW, data-cache line address and write data.
REQ-008 SHALL have ports: ic_gnt, dc_gnt  out  1  one-cycle grant pulses; ic_done, dc_done  out  1  one-cycle completion pulses.
REQ-009 SHALL have ports: rdata  out  WORDW, and ic_rvalid, dc_rvalid  out  1  read beat to owner; dc_wready  out  1  write beat accepted.
REQ-010 SHALL have ports: ln_valid  out  1, ln_cmd  out  lnext_cmd_t, ln_addr  out  LINEADDRBITS, ln_ready  in  1  next-level command handshake.
REQ-011 SHALL have ports: ln_rdata  in  WORDW, ln_rvalid  in  1, ln_wdata  out  WORDW, ln_wready  in  1  next-level data beats.

Function
REQ-012 SHALL implement states IDLE, ISSUE, XFER, DONE; one transaction outstanding.
REQ-013 IDLE: any valid request at a rising edge SHALL latch owner, cmd and addr, and move to ISSUE. ic cmd is always READ_OUT. dc_req with dc_cmd=NOP SHALL be ignored.
REQ-014 Both requesting in the same cycle SHALL grant the requester not granted last (round-robin); the pointer updates on every grant.
REQ-015 ISSUE first cycle SHALL pulse owner gnt; ln_valid, ln_cmd, ln_addr SHALL hold stable until a cycle with ln_ready=1, then move to XFER. Zero wait yields ISSUE for exactly 1 cycle.
REQ-016 XFER read: each ln_rvalid cycle SHALL forward ln_rdata to rdata with owner rvalid the same cycle (combinational) and increment beat count.
REQ-017 XFER write: ln_wdata SHALL equal dc_wdata; dc_wready SHALL equal ln_wready; beat counts when ln_wready=1.
REQ-018 Beat count SHALL be $clog2(BEATS)+1 bits, cleared on entry to XFER; on the BEATS-th beat SHALL move to DONE.
REQ-019 DONE SHALL pulse owner done for exactly one cycle, then return to IDLE; a request may be accepted on the following edge (min 3+BEATS cycles per transaction).
REQ-020 Requests arriving while not IDLE SHALL wait; ln_rvalid/ln_wready outside XFER SHALL be ignored.
REQ-021 Non-owner rvalid, gnt, done SHALL be 0 at all times.

Reset
REQ-022 reset_n low SHALL immediately force IDLE, all outputs 0, ln_cmd=NOP, beat count 0, round-robin pointer favouring ic; an in-flight transaction SHALL be abandoned with no done pulse.

Configuration
REQ-023 With LNEXT_STATS_EN defined SHALL add 32-bit saturating counters ic_grants, dc_grants, conflicts (both requesting in IDLE), exposed as outputs, cleared by reset; without it these ports and logic SHALL not exist.

Structure
REQ-024 lnext_cmd_t (NOP, READ_OUT, WRITE_OUT) and the state enum SHALL live in cachePkg.
REQ-025 Round-robin selection SHALL be a sub-module rr_arb2 (req[1:0], advance -> onehot grant).

Verification
REQ-026 ic_req only, ic_addr=26'h0000123, ln_ready=1, 16 rvalid beats -> ic_gnt cycle 1, ln_cmd=READ_OUT ln_addr=26'h0000123, 16 ic_rvalid, ic_done after beat 16.
REQ-027 ic_req and dc_req same edge after reset -> ic granted first, dc granted on IDLE after ic_done; repeat -> dc first.
REQ-028 dc WRITE_OUT, ln_ready low 5 cycles -> ln_valid/addr held 5 cycles, then 16 dc_wready beats with ln_wdata=dc_wdata, dc_done once.
REQ-029 reset_n low during XFER beat 7 -> outputs 0 next sample, no done pulse; new ic_req afterwards completes normally.
REQ-030 dc_req with dc_cmd=NOP -> no grant, ln_valid stays 0; with LNEXT_STATS_EN, conflict count increments once per simultaneous-request IDLE cycle.
